pulse_train_gen: RTL and testbench

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

---
 rtl/pulse_train_gen_if.sv | 24 ++
 rtl/pulse_train_gen.sv | 102 ++++++++++
 tb/tb_pulse_train_gen.sv | 138 +++++++++++++
 3 files changed

// File: rtl/pulse_train_gen_if.sv
// Control/status bundle for pulse_train_gen: train request, abort, phase lengths
// and the generated waveform with its busy/done status.
interface pulse_train_gen_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic             abort;
  logic [CNT_W-1:0] high_len;
  logic [CNT_W-1:0] low_len;
  logic [CNT_W-1:0] num_pulses;
  logic             signal;
  logic             busy;
  logic             done;

  modport master (
    output start, abort, high_len, low_len, num_pulses,
    input  signal, busy, done
  );

  modport slave (
    input  start, abort, high_len, low_len, num_pulses,
    output signal, busy, done
  );
endinterface

// File: rtl/pulse_train_gen.sv
// Programmable pulse train generator: N pulses of H high cycles separated by
// max(L,1) low cycles, with abort, degenerate-request handling and done strobe.
module pulse_train_gen #(
  parameter int CNT_W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  pulse_train_gen_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO = '0;

  state_t           state_reg;
  logic [CNT_W-1:0] high_len_reg;
  logic [CNT_W-1:0] low_len_reg;
  logic [CNT_W-1:0] phase_cnt_reg;
  logic [CNT_W-1:0] pulses_left_reg;
  logic             signal_reg;
  logic             busy_reg;
  logic             done_reg;
  logic [CNT_W-1:0] low_eff;

  // A zero low length still needs one low cycle so every pulse has its own falling edge.
  assign low_eff = (low_len_reg == ZERO) ? ONE : low_len_reg;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg       <= IDLE;
      high_len_reg    <= ZERO;
      low_len_reg     <= ZERO;
      phase_cnt_reg   <= ZERO;
      pulses_left_reg <= ZERO;
      signal_reg      <= 1'b0;
      busy_reg        <= 1'b0;
      done_reg        <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (bus.abort) begin
        state_reg  <= IDLE;
        signal_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (bus.start) begin
              if (bus.num_pulses != ZERO && bus.high_len != ZERO) begin
                high_len_reg    <= bus.high_len;
                low_len_reg     <= bus.low_len;
                phase_cnt_reg   <= bus.high_len;
                pulses_left_reg <= bus.num_pulses;
                state_reg       <= HIGH;
                signal_reg      <= 1'b1;
                busy_reg        <= 1'b1;
              end else begin
                done_reg <= 1'b1;
              end
            end
          end
          HIGH: begin
            if (phase_cnt_reg == ONE) begin
              signal_reg <= 1'b0;
              if (pulses_left_reg == ONE) begin
                // Last pulse: no trailing low phase, completion coincides with the falling edge.
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
                done_reg  <= 1'b1;
              end else begin
                state_reg       <= LOW;
                phase_cnt_reg   <= low_eff;
                pulses_left_reg <= pulses_left_reg - ONE;
              end
            end else begin
              phase_cnt_reg <= phase_cnt_reg - ONE;
            end
          end
          LOW: begin
            if (phase_cnt_reg == ONE) begin
              state_reg     <= HIGH;
              phase_cnt_reg <= high_len_reg;
              signal_reg    <= 1'b1;
            end else begin
              phase_cnt_reg <= phase_cnt_reg - ONE;
            end
          end
          default: begin
            state_reg  <= IDLE;
            signal_reg <= 1'b0;
            busy_reg   <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.signal = signal_reg;
  assign bus.busy   = busy_reg;
  assign bus.done   = done_reg;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Directed bench for pulse_train_gen: hand-written per-cycle waveforms and busy lengths.
module tb_pulse_train_gen;

  localparam int CNT_W = 8;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  pulse_train_gen_if #(.CNT_W(CNT_W)) bus ();

  pulse_train_gen #(.CNT_W(CNT_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    vectors++;
    if (obs != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int h, input int l, input int n);
    bus.high_len   = CNT_W'(h);
    bus.low_len    = CNT_W'(l);
    bus.num_pulses = CNT_W'(n);
    bus.start      = 1'b1;
  endtask

  // Character i of each string is the expected value on cycle i+1 after the call.
  task automatic expect_wave(input string tag, input string sig, input string bsy, input string dn);
    for (int i = 0; i < sig.len(); i++) begin
      step();
      bus.start = 1'b0;
      check($sformatf("%s.sig[%0d]", tag, i + 1), int'(bus.signal), int'(sig[i] == "1"));
      check($sformatf("%s.busy[%0d]", tag, i + 1), int'(bus.busy), int'(bsy[i] == "1"));
      check($sformatf("%s.done[%0d]", tag, i + 1), int'(bus.done), int'(dn[i] == "1"));
    end
    $display("vector %s: %0d cycles checked", tag, sig.len());
  endtask

  task automatic measure(input string tag, input int h, input int l, input int n, input int exp_busy);
    int cnt;
    cnt = 0;
    issue(h, l, n);
    step();
    bus.start = 1'b0;
    while (bus.busy && cnt < 4000) begin
      cnt++;
      step();
    end
    check({tag, ".busy_len"}, cnt, exp_busy);
    check({tag, ".done"}, int'(bus.done), 1);
    check({tag, ".sig_end"}, int'(bus.signal), 0);
    step();
    check({tag, ".done_once"}, int'(bus.done), 0);
    $display("vector %s: H=%0d L=%0d N=%0d busy %0d cycles", tag, h, l, n, cnt);
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n          = 1'b0;
    bus.start      = 1'b0;
    bus.abort      = 1'b0;
    bus.high_len   = '0;
    bus.low_len    = '0;
    bus.num_pulses = '0;

    step();
    step();
    check("reset.sig", int'(bus.signal), 0);
    check("reset.busy", int'(bus.busy), 0);
    check("reset.done", int'(bus.done), 0);
    rst_n = 1'b1;

    issue(3, 2, 2);
    expect_wave("h3l2n2", "1110011100", "1111111100", "0000000010");

    issue(1, 0, 3);
    expect_wave("h1l0n3", "1010100", "1111100", "0000010");

    issue(4, 1, 0);
    expect_wave("n0", "000", "000", "100");

    issue(0, 1, 2);
    expect_wave("h0", "000", "000", "100");

    // Abort during the low phase of the first pulse.
    issue(5, 5, 4);
    expect_wave("abort_run", "1111100", "1111111", "0000000");
    bus.abort = 1'b1;
    expect_wave("abort_hit", "0", "0", "0");
    bus.abort = 1'b0;
    expect_wave("abort_after", "000", "000", "000");

    bus.abort = 1'b1;
    issue(3, 1, 2);
    expect_wave("abort_start", "00", "00", "00");
    bus.abort = 1'b0;

    // Restart attempts with different parameters while busy must not disturb the train.
    issue(2, 1, 2);
    expect_wave("restart_a", "1", "1", "0");
    issue(7, 3, 5);
    expect_wave("restart_b", "10", "11", "00");
    bus.start = 1'b1;
    expect_wave("restart_c", "1100", "1100", "0010");

    issue(4, 1, 2);
    expect_wave("rst_run", "11", "11", "00");
    rst_n = 1'b0;
    expect_wave("rst_hit", "0", "0", "0");
    rst_n = 1'b1;
    issue(2, 0, 1);
    expect_wave("rst_after", "110", "110", "001");

    measure("len_h3l0n4", 3, 0, 4, 15);
    measure("len_h255n1", 255, 0, 1, 255);
    measure("len_max", 255, 255, 2, 765);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
